// File: rtl/axil_cmd_queue.sv
// axil_cmd_queue: AXI4-Lite register file that stages an NREG-word descriptor and
// queues committed descriptors in a DEPTH-entry FIFO toward an engine config stream.
// Writing word 0 (CMD) commits the staged descriptor. STATUS and BUSYCNT sit after it.
// Optional feature macro: CMDQ_IRQ_EN adds the pop-completion interrupt (CMDQ_IRQ port
// and STATUS[15]). Without it the port is absent and STATUS[15] reads 0.
module axil_cmd_queue #(
    parameter int unsigned NREG      = 4,
    parameter int unsigned W         = 32,
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h7000_0000
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic [31:0]         S_AXI_AWADDR,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,
    input  logic [W-1:0]        S_AXI_WDATA,
    input  logic [W/8-1:0]      S_AXI_WSTRB,
    input  logic                S_AXI_WVALID,
    output logic                S_AXI_WREADY,
    output logic [1:0]          S_AXI_BRESP,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,
    input  logic [31:0]         S_AXI_ARADDR,
    input  logic                S_AXI_ARVALID,
    output logic                S_AXI_ARREADY,
    output logic [W-1:0]        S_AXI_RDATA,
    output logic [1:0]          S_AXI_RRESP,
    output logic                S_AXI_RVALID,
    input  logic                S_AXI_RREADY,
    output logic                CONFIG_VALID,
    input  logic                CONFIG_READY,
    output logic [NREG*W-1:0]   CONFIG_DATA
`ifdef CMDQ_IRQ_EN
    ,
    output logic                CMDQ_IRQ
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned NB = W / 8;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic R_IDLE = 1'b0;
    localparam logic R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // write channel
    logic [1:0]     w_state, w_state_nxt;
    logic           aw_ready_nxt, w_ready_nxt, b_valid_nxt;
    logic [1:0]     b_resp_nxt;
    logic           aw_take, w_beat;
    logic           w_hit_q;
    logic [3:0]     w_idx_q;
    logic           wr_err;

    // read channel
    logic           r_state, r_state_nxt;
    logic           ar_ready_nxt, r_valid_nxt;
    logic           ar_take;
    logic           r_hit;
    logic [3:0]     r_idx;
    logic [W-1:0]   rd_word;
    logic           rd_err;

    // register file and queue
    logic [W-1:0]       stage_q   [NREG];
    logic [W-1:0]       stage_nxt [NREG];
    logic [NREG*W-1:0]  push_data;
    logic [NREG*W-1:0]  mem_q     [DEPTH];
    logic [NREG*W-1:0]  head_nxt;
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q, rd_ptr_inc;
    logic [CW-1:0]      count_q, count_nxt;
    logic               full, empty;
    logic               cmd_beat, push, pop, ovf_evt;
    logic               status_wr, busy_clr;
    logic               ovf_q;
    logic               irq_q;
    logic [W-1:0]       busy_q;
    logic [W-1:0]       status_word;

    // address LSBs are not part of the word decode
    logic unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop      = CONFIG_VALID && CONFIG_READY;
    assign cmd_beat = w_beat && w_hit_q && (w_idx_q == 4'd0);
    assign ovf_evt  = cmd_beat && full && !pop;
    assign push     = cmd_beat && (!full || pop);
    assign status_wr = w_beat && w_hit_q && (w_idx_q == 4'(NREG)) && S_AXI_WSTRB[1];
    assign busy_clr  = w_beat && w_hit_q && (w_idx_q == 4'(NREG + 1));
    assign wr_err    = !w_hit_q || (32'(w_idx_q) >= NREG + 2) || ovf_evt;
    assign rd_ptr_inc = rd_ptr_q + PW'(1);

    assign status_word = W'({16'b0, irq_q, ovf_q, full, empty, 7'b0, 5'(count_q)});

    // Write FSM: next state and next values of the registered handshake outputs
    always_comb begin
        w_state_nxt  = w_state;
        aw_ready_nxt = S_AXI_AWREADY;
        w_ready_nxt  = S_AXI_WREADY;
        b_valid_nxt  = S_AXI_BVALID;
        b_resp_nxt   = S_AXI_BRESP;
        aw_take      = 1'b0;
        w_beat       = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (S_AXI_AWVALID) begin
                    aw_take      = 1'b1;
                    w_state_nxt  = W_DATA;
                    aw_ready_nxt = 1'b0;
                    w_ready_nxt  = 1'b1;
                end
            end
            W_DATA: begin
                if (S_AXI_WVALID) begin
                    w_beat      = 1'b1;
                    w_state_nxt = W_RESP;
                    w_ready_nxt = 1'b0;
                    b_valid_nxt = 1'b1;
                    b_resp_nxt  = wr_err ? RESP_SLVERR : RESP_OKAY;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_state_nxt  = W_IDLE;
                    b_valid_nxt  = 1'b0;
                    aw_ready_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt  = W_IDLE;
                aw_ready_nxt = 1'b1;
                w_ready_nxt  = 1'b0;
                b_valid_nxt  = 1'b0;
            end
        endcase
    end

    // Write FSM state, handshake outputs and latched address decode
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            w_hit_q       <= 1'b0;
            w_idx_q       <= 4'd0;
        end else begin
            w_state       <= w_state_nxt;
            S_AXI_AWREADY <= aw_ready_nxt;
            S_AXI_WREADY  <= w_ready_nxt;
            S_AXI_BVALID  <= b_valid_nxt;
            S_AXI_BRESP   <= b_resp_nxt;
            if (aw_take) begin
                w_hit_q <= (S_AXI_AWADDR[31:6] == BASE_ADDR[31:6]);
                w_idx_q <= S_AXI_AWADDR[5:2];
            end
        end
    end

    // Staging words after this cycle's strobed write; the commit snapshot uses these
    always_comb begin
        push_data = '0;
        for (int i = 0; i < NREG; i++) begin
            stage_nxt[i] = stage_q[i];
            if (w_beat && w_hit_q && (w_idx_q == 4'(i))) begin
                for (int b = 0; b < NB; b++) begin
                    if (S_AXI_WSTRB[b]) begin
                        stage_nxt[i][b*8 +: 8] = S_AXI_WDATA[b*8 +: 8];
                    end
                end
            end
            push_data[i*W +: W] = stage_nxt[i];
        end
    end

    // Staging register file
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NREG; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                stage_q[i] <= stage_nxt[i];
            end
        end
    end

    // Queue storage; contents only matter between the pointers, so no reset
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Next occupancy and next head, covering push into an empty or draining queue
    always_comb begin
        count_nxt = count_q;
        if (push && !pop) begin
            count_nxt = count_q + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count_q - CW'(1);
        end
        head_nxt = CONFIG_DATA;
        if (pop) begin
            if (count_q != CW'(1)) begin
                head_nxt = mem_q[rd_ptr_inc];
            end else if (push) begin
                head_nxt = push_data;
            end
        end else if (push && empty) begin
            head_nxt = push_data;
        end
    end

    // Queue pointers, occupancy and registered head
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            CONFIG_VALID <= 1'b0;
            CONFIG_DATA  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_inc;
            end
            count_q      <= count_nxt;
            CONFIG_VALID <= (count_nxt != '0);
            CONFIG_DATA  <= head_nxt;
        end
    end

    // Overflow flag: set by a rejected commit, cleared by W1C
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ovf_q <= 1'b0;
        end else if (ovf_evt) begin
            ovf_q <= 1'b1;
        end else if (status_wr && S_AXI_WDATA[14]) begin
            ovf_q <= 1'b0;
        end
    end

    // Busy-cycle counter: software write clears and wins over the increment
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            busy_q <= '0;
        end else if (busy_clr) begin
            busy_q <= '0;
        end else if (CONFIG_VALID && (busy_q != '1)) begin
            busy_q <= busy_q + W'(1);
        end
    end

`ifdef CMDQ_IRQ_EN
    logic irq_clr;
    assign irq_clr  = status_wr && S_AXI_WDATA[15];
    assign CMDQ_IRQ = irq_q;

    // Pop-completion flag: a pop on the same edge as the W1C keeps it set
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            irq_q <= 1'b0;
        end else if (pop) begin
            irq_q <= 1'b1;
        end else if (irq_clr) begin
            irq_q <= 1'b0;
        end
    end
`else
    assign irq_q = 1'b0;
`endif

    // Read address decode into the word returned on RDATA
    always_comb begin
        r_hit   = (S_AXI_ARADDR[31:6] == BASE_ADDR[31:6]);
        r_idx   = S_AXI_ARADDR[5:2];
        rd_word = '0;
        rd_err  = 1'b1;
        if (r_hit) begin
            for (int i = 0; i < NREG; i++) begin
                if (r_idx == 4'(i)) begin
                    rd_word = stage_q[i];
                    rd_err  = 1'b0;
                end
            end
            if (r_idx == 4'(NREG)) begin
                rd_word = status_word;
                rd_err  = 1'b0;
            end
            if (r_idx == 4'(NREG + 1)) begin
                rd_word = busy_q;
                rd_err  = 1'b0;
            end
        end
    end

    // Read FSM: next state and next values of the registered handshake outputs
    always_comb begin
        r_state_nxt  = r_state;
        ar_ready_nxt = S_AXI_ARREADY;
        r_valid_nxt  = S_AXI_RVALID;
        ar_take      = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (S_AXI_ARVALID) begin
                    ar_take      = 1'b1;
                    r_state_nxt  = R_DATA;
                    ar_ready_nxt = 1'b0;
                    r_valid_nxt  = 1'b1;
                end
            end
            default: begin
                if (S_AXI_RREADY) begin
                    r_state_nxt  = R_IDLE;
                    ar_ready_nxt = 1'b1;
                    r_valid_nxt  = 1'b0;
                end
            end
        endcase
    end

    // Read FSM state and registered read response
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b1;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            r_state       <= r_state_nxt;
            S_AXI_ARREADY <= ar_ready_nxt;
            S_AXI_RVALID  <= r_valid_nxt;
            if (ar_take) begin
                S_AXI_RDATA <= rd_word;
                S_AXI_RRESP <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

endmodule

// File: tb/tb_axil_cmd_queue.sv
// Directed bench for axil_cmd_queue (default parameters NREG=4, DEPTH=4).
module tb_axil_cmd_queue;

    logic         ACLK;
    logic         ARESETN;
    logic [31:0]  S_AXI_AWADDR;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [31:0]  S_AXI_ARADDR;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic         CONFIG_VALID;
    logic         CONFIG_READY;
    logic [127:0] CONFIG_DATA;
`ifdef CMDQ_IRQ_EN
    logic         CMDQ_IRQ;
    localparam logic [31:0] IRQB = 32'h0000_8000;
`else
    localparam logic [31:0] IRQB = 32'h0000_0000;
`endif

    localparam logic [31:0] A_CMD    = 32'h7000_0000;
    localparam logic [31:0] A_W1     = 32'h7000_0004;
    localparam logic [31:0] A_W2     = 32'h7000_0008;
    localparam logic [31:0] A_W3     = 32'h7000_000C;
    localparam logic [31:0] A_STATUS = 32'h7000_0010;
    localparam logic [31:0] A_BUSY   = 32'h7000_0014;

    int n_checks;
    int n_fail;

    axil_cmd_queue dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .CONFIG_VALID  (CONFIG_VALID),
        .CONFIG_READY  (CONFIG_READY),
        .CONFIG_DATA   (CONFIG_DATA)
`ifdef CMDQ_IRQ_EN
        ,
        .CMDQ_IRQ      (CMDQ_IRQ)
`endif
    );

    always #5 ACLK = ~ACLK;

    // One AXI-lite write; optionally pops the queue head on the W beat edge
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic pop_at_w,
                             output logic [1:0] resp);
        int n;
        @(negedge ACLK);
        S_AXI_AWADDR = addr;
        S_AXI_AWVALID = 1'b1;
        n = 0;
        while (!S_AXI_AWREADY && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) begin
            $display("FAIL aw_timeout: AWREADY=%0b after %0d cycles, required 1", S_AXI_AWREADY, n);
            n_fail++; n_checks++;
        end
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        @(negedge ACLK);
        S_AXI_WDATA = data;
        S_AXI_WSTRB = strb;
        S_AXI_WVALID = 1'b1;
        n = 0;
        while (!S_AXI_WREADY && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) begin
            $display("FAIL w_timeout: WREADY=%0b after %0d cycles, required 1", S_AXI_WREADY, n);
            n_fail++; n_checks++;
        end
        CONFIG_READY = pop_at_w;
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
        CONFIG_READY = 1'b0;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b1;
        n = 0;
        while (!S_AXI_BVALID && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) begin
            $display("FAIL b_timeout: BVALID=%0b after %0d cycles, required 1", S_AXI_BVALID, n);
            n_fail++; n_checks++;
        end
        resp = S_AXI_BRESP;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
    endtask

    // One AXI-lite read
    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        @(negedge ACLK);
        S_AXI_ARADDR = addr;
        S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!S_AXI_ARREADY && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) begin
            $display("FAIL ar_timeout: ARREADY=%0b after %0d cycles, required 1", S_AXI_ARREADY, n);
            n_fail++; n_checks++;
        end
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        @(negedge ACLK);
        S_AXI_RREADY = 1'b1;
        n = 0;
        while (!S_AXI_RVALID && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) begin
            $display("FAIL r_timeout: RVALID=%0b after %0d cycles, required 1", S_AXI_RVALID, n);
            n_fail++; n_checks++;
        end
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    // Hold CONFIG_READY for exactly one edge
    task automatic pulse_ready();
        @(negedge ACLK);
        CONFIG_READY = 1'b1;
        @(posedge ACLK); #1;
        CONFIG_READY = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        @(negedge ACLK);
        if ({S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID, CONFIG_VALID} !== 6'b110000) begin
            $display("FAIL reset_handshakes: got %b, required 110000",
                     {S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID, CONFIG_VALID});
            n_fail++;
        end
        n_checks++;
        if (CONFIG_DATA !== 128'h0 || S_AXI_RDATA !== 32'h0 || S_AXI_BRESP !== 2'b00 || S_AXI_RRESP !== 2'b00) begin
            $display("FAIL reset_data: CONFIG_DATA=%h RDATA=%h BRESP=%b RRESP=%b, required all 0",
                     CONFIG_DATA, S_AXI_RDATA, S_AXI_BRESP, S_AXI_RRESP);
            n_fail++;
        end
        n_checks++;
        axi_read(A_STATUS, d, r);
        if (d !== 32'h0000_1000 || r !== 2'b00) begin
            $display("FAIL reset_status: got %h/%b, required 00001000/00", d, r);
            n_fail++;
        end
        n_checks++;
        axi_read(A_W1, d, r);
        if (d !== 32'h0) begin
            $display("FAIL reset_stage: got %h, required 00000000", d);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_commit();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(A_W1, 32'h1000, 4'hF, 1'b0, r);
        axi_write(A_W2, 32'h2000, 4'hF, 1'b0, r);
        axi_write(A_W3, 32'h40, 4'hF, 1'b0, r);
        axi_write(A_CMD, 32'h1, 4'hF, 1'b0, r);
        if (r !== 2'b00 || CONFIG_VALID !== 1'b1) begin
            $display("FAIL commit_resp: BRESP=%b VALID=%b, required 00/1", r, CONFIG_VALID);
            n_fail++;
        end
        n_checks++;
        if (CONFIG_DATA !== {32'h40, 32'h2000, 32'h1000, 32'h1}) begin
            $display("FAIL commit_data: got %h, required %h", CONFIG_DATA, {32'h40, 32'h2000, 32'h1000, 32'h1});
            n_fail++;
        end
        n_checks++;
        axi_read(A_STATUS, d, r);
        if (d !== 32'h0000_0001) begin
            $display("FAIL commit_status: got %h, required 00000001", d);
            n_fail++;
        end
        n_checks++;
        pulse_ready();
        @(negedge ACLK);
        if (CONFIG_VALID !== 1'b0) begin
            $display("FAIL pop_valid: got %b, required 0", CONFIG_VALID);
            n_fail++;
        end
        n_checks++;
        axi_read(A_STATUS, d, r);
        if (d !== (32'h0000_1000 | IRQB)) begin
            $display("FAIL pop_status: got %h, required %h", d, 32'h0000_1000 | IRQB);
            n_fail++;
        end
        n_checks++;
        axi_write(A_STATUS, 32'h8000, 4'hF, 1'b0, r);
    endtask

    task automatic test_wstrb();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(A_W2, 32'hFFFF_FFFF, 4'hF, 1'b0, r);
        axi_write(A_W2, 32'h1234_5678, 4'b0101, 1'b0, r);
        axi_read(A_W2, d, r);
        if (d !== 32'hFF34_FF78) begin
            $display("FAIL wstrb_merge: got %h, required ff34ff78", d);
            n_fail++;
        end
        n_checks++;
        axi_write(A_W2, 32'h2000, 4'hF, 1'b0, r);
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [1:0]  r;
        logic [1:0]  exp_r;
        for (int i = 0; i < 5; i++) begin
            axi_write(A_CMD, 32'(i), 4'hF, 1'b0, r);
            exp_r = (i == 4) ? 2'b10 : 2'b00;
            if (r !== exp_r) begin
                $display("FAIL fill_bresp[%0d]: got %b, required %b", i, r, exp_r);
                n_fail++;
            end
            n_checks++;
        end
        axi_read(A_STATUS, d, r);
        if (d !== 32'h0000_6004) begin
            $display("FAIL full_status: got %h, required 00006004", d);
            n_fail++;
        end
        n_checks++;
        if (CONFIG_DATA[31:0] !== 32'h0) begin
            $display("FAIL full_head: got %h, required 00000000", CONFIG_DATA[31:0]);
            n_fail++;
        end
        n_checks++;
        axi_read(A_CMD, d, r);
        if (d !== 32'h4) begin
            $display("FAIL ovf_stage: got %h, required 00000004", d);
            n_fail++;
        end
        n_checks++;
        axi_write(A_STATUS, 32'h4000, 4'hF, 1'b0, r);
        axi_read(A_STATUS, d, r);
        if (d !== 32'h0000_2004) begin
            $display("FAIL ovf_w1c: got %h, required 00002004", d);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_full_push_pop();
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] exp_w0 [4];
        exp_w0 = '{32'h1, 32'h2, 32'h3, 32'h5};
        axi_write(A_CMD, 32'h5, 4'hF, 1'b1, r);
        if (r !== 2'b00) begin
            $display("FAIL pushpop_bresp: got %b, required 00", r);
            n_fail++;
        end
        n_checks++;
        axi_read(A_STATUS, d, r);
        if (d !== (32'h0000_2004 | IRQB)) begin
            $display("FAIL pushpop_status: got %h, required %h", d, 32'h0000_2004 | IRQB);
            n_fail++;
        end
        n_checks++;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            if (CONFIG_VALID !== 1'b1 || CONFIG_DATA !== {32'h40, 32'h2000, 32'h1000, exp_w0[i]}) begin
                $display("FAIL drain[%0d]: valid=%b data=%h, required 1/%h", i, CONFIG_VALID,
                         CONFIG_DATA, {32'h40, 32'h2000, 32'h1000, exp_w0[i]});
                n_fail++;
            end
            n_checks++;
            pulse_ready();
        end
        @(negedge ACLK);
        if (CONFIG_VALID !== 1'b0) begin
            $display("FAIL drain_empty: valid=%b, required 0", CONFIG_VALID);
            n_fail++;
        end
        n_checks++;
        axi_write(A_STATUS, 32'h8000, 4'hF, 1'b0, r);
    endtask

    task automatic test_decode();
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(32'h7000_0040, d, r);
        if (r !== 2'b10 || d !== 32'h0) begin
            $display("FAIL rd_miss_hi: got %h/%b, required 00000000/10", d, r);
            n_fail++;
        end
        n_checks++;
        axi_read(32'h6000_0000, d, r);
        if (r !== 2'b10) begin
            $display("FAIL rd_miss_base: RRESP=%b, required 10", r);
            n_fail++;
        end
        n_checks++;
        axi_read(32'h7000_0018, d, r);
        if (r !== 2'b10) begin
            $display("FAIL rd_unmapped: RRESP=%b, required 10", r);
            n_fail++;
        end
        n_checks++;
        axi_write(32'h6000_0000, 32'hDEAD, 4'hF, 1'b0, r);
        if (r !== 2'b10 || CONFIG_VALID !== 1'b0) begin
            $display("FAIL wr_miss: BRESP=%b VALID=%b, required 10/0", r, CONFIG_VALID);
            n_fail++;
        end
        n_checks++;
        axi_write(32'h7000_001C, 32'hBEEF, 4'hF, 1'b0, r);
        if (r !== 2'b10) begin
            $display("FAIL wr_unmapped: BRESP=%b, required 10", r);
            n_fail++;
        end
        n_checks++;
        axi_read(A_CMD, d, r);
        if (d !== 32'h5 || r !== 2'b00) begin
            $display("FAIL miss_no_side_effect: got %h/%b, required 00000005/00", d, r);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_busycnt();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(A_BUSY, 32'h1234, 4'hF, 1'b0, r);
        axi_read(A_BUSY, d, r);
        if (d !== 32'h0 || r !== 2'b00) begin
            $display("FAIL busy_clear: got %h/%b, required 00000000/00", d, r);
            n_fail++;
        end
        n_checks++;
        axi_write(A_CMD, 32'h7, 4'hF, 1'b0, r);
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        CONFIG_READY = 1'b1;
        @(posedge ACLK); #1;
        CONFIG_READY = 1'b0;
        axi_read(A_BUSY, d, r);
        if (d !== 32'd5) begin
            $display("FAIL busy_count: got %0d, required 5", d);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_irq();
        logic [31:0] d;
        logic [1:0]  r;
`ifdef CMDQ_IRQ_EN
        @(negedge ACLK);
        if (CMDQ_IRQ !== 1'b1) begin
            $display("FAIL irq_set: got %b, required 1", CMDQ_IRQ);
            n_fail++;
        end
        n_checks++;
        axi_read(A_STATUS, d, r);
        if (d !== 32'h0000_9000) begin
            $display("FAIL irq_status: got %h, required 00009000", d);
            n_fail++;
        end
        n_checks++;
        axi_write(A_STATUS, 32'h8000, 4'hF, 1'b0, r);
        @(negedge ACLK);
        if (CMDQ_IRQ !== 1'b0) begin
            $display("FAIL irq_w1c: got %b, required 0", CMDQ_IRQ);
            n_fail++;
        end
        n_checks++;
`else
        axi_read(A_STATUS, d, r);
        if (d !== 32'h0000_1000) begin
            $display("FAIL noirq_status: got %h, required 00001000", d);
            n_fail++;
        end
        n_checks++;
`endif
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(A_CMD, 32'h9, 4'hF, 1'b0, r);
        @(negedge ACLK);
        S_AXI_AWADDR = A_W1;
        S_AXI_AWVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        @(negedge ACLK);
        if (S_AXI_WREADY !== 1'b1 || S_AXI_AWREADY !== 1'b0) begin
            $display("FAIL midwr_in_wdata: WREADY=%b AWREADY=%b, required 1/0", S_AXI_WREADY, S_AXI_AWREADY);
            n_fail++;
        end
        n_checks++;
        ARESETN = 1'b0;
        #1;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, CONFIG_VALID} !== 4'b1000 || CONFIG_DATA !== 128'h0) begin
            $display("FAIL midwr_reset: AW/W/B/CV=%b data=%h, required 1000/0",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, CONFIG_VALID}, CONFIG_DATA);
            n_fail++;
        end
        n_checks++;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        axi_read(A_CMD, d, r);
        if (d !== 32'h0) begin
            $display("FAIL midwr_stage: got %h, required 00000000", d);
            n_fail++;
        end
        n_checks++;
        axi_read(A_STATUS, d, r);
        if (d !== 32'h0000_1000) begin
            $display("FAIL midwr_status: got %h, required 00001000", d);
            n_fail++;
        end
        n_checks++;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        ACLK = 1'b0;
        ARESETN = 1'b0;
        S_AXI_AWADDR = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0;
        S_AXI_WSTRB = '0;
        S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        CONFIG_READY = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;

        test_reset();
        test_commit();
        test_wstrb();
        test_overflow();
        test_full_push_pop();
        test_decode();
        test_busycnt();
        test_irq();
        test_reset_mid_write();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
